rr_arb_mux_4_1: RTL and testbench

RR_ARB_MUX_4_1 -- requirements
Module: rr_arb_mux_4_1

---
 rtl/rr_arb_pkg.sv | 44 ++++
 rtl/mux_4_1.sv | 28 ++
 rtl/rr_arb_mux_4_1.sv | 73 +++++++
 tb/tb_rr_arb_mux_4_1.sv | 131 +++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants, types and helpers for the 4:1 round-robin arbitrated mux.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: N_REQ / DATA_W sizing, sel_t requester index, round-robin pick
// and one-hot-to-index helpers used by the arbiter.
package rr_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 4;

    typedef logic [1:0] sel_t;

    // Round-robin pick: first set bit of req searching upward from last+1,
    // wrapping around. Returns a one-hot vector, or zero when req is zero.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input sel_t last);
        logic [N_REQ-1:0] g;
        logic             found;
        sel_t             idx;
        g     = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            // 2-bit add wraps naturally modulo N_REQ
            idx = last + sel_t'(k);
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    // Index of the set bit of a one-hot (or zero) vector; zero maps to 0.
    function automatic sel_t onehot_idx(input logic [N_REQ-1:0] oh);
        sel_t idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = sel_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// Purpose: plain combinational 4:1 data mux.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake on this block.
//
// Ports: d0..d3 data inputs, sel index, y selected data.
module mux_4_1
    import rr_arb_pkg::*;
(
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    input  sel_t              sel,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Purpose: 4-requester round-robin arbiter feeding a registered 4:1 data mux.
// Latency: 1 cycle from input grant to y/sel/out_valid.
// Backpressure: in_ready drops to 0 while the output beat is held (out_valid & !out_ready).
//
// Ports: clk, rst (sync, active-high); d0..d3 requester data; in_valid/in_ready
// per-requester handshake; out_valid/out_ready output handshake; y registered
// data; sel registered index of the requester that produced y.
module rr_arb_mux_4_1
    import rr_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    input  logic [N_REQ-1:0]  in_valid,
    output logic [N_REQ-1:0]  in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output sel_t              sel
);

    sel_t              last;
    logic              out_free;
    logic              grant;
    sel_t              grant_idx;
    logic [DATA_W-1:0] mux_y;

    // Register may take a new beat when empty or being drained this cycle;
    // accepting while draining gives one beat per cycle with no bubble.
    assign out_free = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        if (!rst && out_free) begin
            in_ready = rr_pick(in_valid, last);
        end
    end

    assign grant     = |in_ready;
    assign grant_idx = onehot_idx(in_ready);

    // Only the granted requester's data is ever captured, so X on an idle
    // requester cannot reach y.
    mux_4_1 u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (grant_idx),
        .y   (mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            sel       <= '0;
            last      <= 2'd3;  // first priority goes to requester 0
        end else if (grant) begin
            out_valid <= 1'b1;
            y         <= mux_y;
            sel       <= grant_idx;
            last      <= grant_idx;
        end else if (out_free) begin
            // drained (or already empty) with nothing new: y/sel hold
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Purpose: directed self-checking bench for rr_arb_mux_4_1.
// Latency: n/a.
// Backpressure: n/a.
module tb_rr_arb_mux_4_1;

    logic       clk;
    logic       rst;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y;
    logic [1:0] sel;

    int errors = 0;
    int checks = 0;

    rr_arb_mux_4_1 dut (
        .clk       (clk),
        .rst       (rst),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [3:0] ey,
                           input logic [1:0] es);
        chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
        chk({tag, ".y"},         {4'd0, y},         {4'd0, ey});
        chk({tag, ".sel"},       {6'd0, sel},       {6'd0, es});
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] er);
        chk({tag, ".in_ready"}, {4'd0, in_ready}, {4'd0, er});
    endtask

    initial begin
        // ---- reset held 2 cycles with all requesters valid ----
        rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
        #1;
        chk_rdy("rst0", 4'b0000);
        tick(); chk_rdy("rst1", 4'b0000); chk_out("rst1", 1'b0, 4'h0, 2'd0);
        tick(); chk_rdy("rst2", 4'b0000); chk_out("rst2", 1'b0, 4'h0, 2'd0);

        // ---- all valid, out_ready=1: strict 0,1,2,3,0 one beat per cycle ----
        rst = 1'b0; #1;
        chk_rdy("rr.g0", 4'b0001);
        tick(); chk_out("rr.b0", 1'b1, 4'hA, 2'd0); chk_rdy("rr.g1", 4'b0010);
        tick(); chk_out("rr.b1", 1'b1, 4'hB, 2'd1); chk_rdy("rr.g2", 4'b0100);
        tick(); chk_out("rr.b2", 1'b1, 4'hC, 2'd2); chk_rdy("rr.g3", 4'b1000);
        tick(); chk_out("rr.b3", 1'b1, 4'hD, 2'd3); chk_rdy("rr.g4", 4'b0001);
        tick(); chk_out("rr.b4", 1'b1, 4'hA, 2'd0);

        // ---- bring last to 1, then 4'b1010 wraps: 3 then 1 ----
        in_valid = 4'b0010; #1;
        chk_rdy("wrap.g1", 4'b0010);
        tick(); chk_out("wrap.b1", 1'b1, 4'hB, 2'd1);
        in_valid = 4'b1010; #1;
        chk_rdy("wrap.g3", 4'b1000);
        tick(); chk_out("wrap.b3", 1'b1, 4'hD, 2'd3); chk_rdy("wrap.g1b", 4'b0010);
        tick(); chk_out("wrap.b1b", 1'b1, 4'hB, 2'd1);

        // ---- backpressure: beat y=7 sel=2 held for 3 cycles ----
        d2 = 4'h7; in_valid = 4'b0100; #1;
        chk_rdy("bp.g2", 4'b0100);
        tick(); chk_out("bp.b2", 1'b1, 4'h7, 2'd2);
        out_ready = 1'b0; in_valid = 4'hF; #1;
        chk_rdy("bp.hold0", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp.hold", 1'b1, 4'h7, 2'd2);
            chk_rdy("bp.hold", 4'b0000);
        end
        out_ready = 1'b1; #1;
        chk_rdy("bp.release", 4'b1000);
        tick(); chk_out("bp.b3", 1'b1, 4'hD, 2'd3);

        // ---- single requester 2 valid, others X ----
        d0 = 4'bxxxx; d1 = 4'bxxxx; d3 = 4'bxxxx; d2 = 4'h5;
        in_valid = 4'b0100; #1;
        chk_rdy("x.g2", 4'b0100);
        tick(); chk_out("x.b2", 1'b1, 4'h5, 2'd2);
        in_valid = 4'b0000; #1;
        chk_rdy("x.idle", 4'b0000);
        tick(); chk_out("x.drain", 1'b0, 4'h5, 2'd2);
        tick(); chk_out("x.idle2", 1'b0, 4'h5, 2'd2);

        // ---- reset pulsed while a beat is stalled ----
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
        in_valid = 4'b0001; #1;
        chk_rdy("mr.g0", 4'b0001);
        tick(); chk_out("mr.b0", 1'b1, 4'hA, 2'd0);
        out_ready = 1'b0; rst = 1'b1; in_valid = 4'hF; #1;
        chk_rdy("mr.inrst", 4'b0000);
        tick(); chk_out("mr.after", 1'b0, 4'h0, 2'd0);
        rst = 1'b0; #1;
        chk_rdy("mr.first", 4'b0001);
        tick(); chk_out("mr.b0b", 1'b1, 4'hA, 2'd0);
        chk_rdy("mr.stall", 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
